// File: rtl/ifetch.sv
// Instruction fetch: one outstanding bus read, results queued in a 2-entry buffer toward decode.
// Latency: instruction visible one cycle after rvalid; minimum two cycles per fetch.
// Backpressure: no request while hold_i, while the buffer (plus pending) is full, or while a response is outstanding.
// Optional: IFETCH_MISALIGN_CHK_EN turns a misaligned pc_i into an error entry instead of a bus request.
module ifetch #(
    parameter logic [31:0] INST_NOP   = 32'h0000_0013,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    input  logic        hold_i,
    output logic        fetch_hold_o,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i,
    output logic        inst_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] pend_addr;

    logic [31:0] mem_addr [FIFO_DEPTH];
    logic [31:0] mem_dat  [FIFO_DEPTH];

    logic        pending;
    logic        space_ok;
    logic        fetch_ok;
    logic        misalign;
    logic        err_push;
    logic        resp_push;
    logic        push;
    logic        pop;
    logic [31:0] push_addr;
    logic [31:0] push_dat;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic        mem_err [FIFO_DEPTH];
    assign misalign = (pc_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign pending  = (state == BUSY);
    assign space_ok = ({1'b0, count} + {2'b00, pending}) < DEPTH;
    // Reset gating keeps the bus quiet while rst is asserted.
    assign fetch_ok = (state == IDLE) & ~flush_i & ~hold_i & space_ok & ~rst;

    assign ibus_req_o   = fetch_ok & ~misalign;
    assign ibus_addr_o  = {pc_i[31:2], 2'b00};
    assign fetch_hold_o = ~(ibus_req_o & ibus_gnt_i);

    assign err_push  = fetch_ok & misalign;
    assign resp_push = (state == BUSY) & ibus_rvalid_i & ~flush_i;
    assign push      = resp_push | err_push;
    assign pop       = inst_valid_o & inst_ready_i;

    assign push_addr = err_push ? pc_i     : pend_addr;
    assign push_dat  = err_push ? INST_NOP : ibus_rdata_i;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ibus_req_o && ibus_gnt_i)
                    state_nxt = BUSY;
            end
            BUSY: begin
                if (ibus_rvalid_i)
                    state_nxt = IDLE;
                else if (flush_i)
                    state_nxt = DROP;
            end
            DROP: begin
                if (ibus_rvalid_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend_addr <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && ibus_req_o && ibus_gnt_i)
                pend_addr <= pc_i;
        end
    end

    // A flush discards everything; the head popped in the same cycle has already been taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (flush_i) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset: outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_dat[wr_ptr]  <= push_dat;
`ifdef IFETCH_MISALIGN_CHK_EN
            mem_err[wr_ptr]  <= err_push;
`endif
        end
    end

    assign inst_valid_o = (count != 2'd0);
    assign inst_o       = inst_valid_o ? mem_dat[rd_ptr]  : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? mem_addr[rd_ptr] : 32'h0;

`ifdef IFETCH_MISALIGN_CHK_EN
    assign inst_err_o = inst_valid_o & mem_err[rd_ptr];
`else
    assign inst_err_o = 1'b0;
`endif

endmodule
